// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue: issues 16-bit code fetches, buffers bytes
// in a circular store, presents the three head bytes to pre-decode and retires consumed bytes.
module prefetch_queue #(
   parameter int QUEUE_SIZE = 6,
   parameter int ADDR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] flush_addr,
   input  logic                  consume,
   input  logic [2:0]            consume_len,
   output logic [3:0]            q_len,
   output logic [7:0]            q0,
   output logic [7:0]            q1,
   output logic [7:0]            q2,
   output logic                  fetch_req,
   output logic [ADDR_WIDTH-1:0] fetch_addr,
   input  logic                  fetch_ack,
   input  logic [15:0]           fetch_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_STALE = 2'd2;
   localparam logic [3:0] DEPTH    = 4'(QUEUE_SIZE);

   // Circular pointer advance; p + n never reaches twice the depth.
   function automatic logic [2:0] ptr_add(input logic [2:0] p, input logic [3:0] n);
      logic [4:0] s;
      s = {2'b00, p} + {1'b0, n};
      if (s >= {1'b0, DEPTH}) begin
         ptr_add = 3'(s - {1'b0, DEPTH});
      end else begin
         ptr_add = s[2:0];
      end
   endfunction

   logic [7:0]            mem_r [8];
   logic [2:0]            head_r;
   logic [2:0]            tail_r;
   logic [3:0]            count_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic                  skip_lo_r;
   logic                  addr_valid_r;
   logic [1:0]            state_r;

   logic [3:0]            len_ext_s;
   logic [3:0]            consumed_s;
   logic [3:0]            free_s;
   logic [3:0]            need_s;
   logic                  start_s;
   logic                  take_s;
   logic [3:0]            enq_cnt_s;
   logic [7:0]            wr_byte0_s;
   logic                  wr_byte1_s;
   logic [2:0]            tail_p1_s;
   logic [2:0]            rd1_idx_s;
   logic [2:0]            rd2_idx_s;

   logic [1:0]            state_nxt_s;
   logic                  req_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_nxt_s;
   logic [ADDR_WIDTH-1:0] pc_nxt_s;
   logic                  skip_nxt_s;
   logic                  valid_nxt_s;
   logic [3:0]            count_nxt_s;
   logic [2:0]            head_nxt_s;
   logic [2:0]            tail_nxt_s;

   assign len_ext_s  = {1'b0, consume_len};
   // Oversized consumes are clamped so the queue empties rather than underflows.
   assign consumed_s = consume ? ((len_ext_s > count_r) ? count_r : len_ext_s) : 4'd0;
   assign free_s     = DEPTH - count_r;
   assign need_s     = pc_r[0] ? 4'd1 : 4'd2;
   assign start_s    = (state_r == ST_IDLE) && addr_valid_r && !flush && (free_s >= need_s);
   assign take_s     = (state_r == ST_FETCH) && fetch_ack && !flush;
   assign enq_cnt_s  = take_s ? (skip_lo_r ? 4'd1 : 4'd2) : 4'd0;
   assign wr_byte0_s = skip_lo_r ? fetch_data[15:8] : fetch_data[7:0];
   assign wr_byte1_s = take_s && !skip_lo_r;
   assign tail_p1_s  = ptr_add(tail_r, 4'd1);
   assign rd1_idx_s  = ptr_add(head_r, 4'd1);
   assign rd2_idx_s  = ptr_add(head_r, 4'd2);

   assign q_len = count_r;
   assign q0    = (count_r > 4'd0) ? mem_r[head_r]    : 8'h00;
   assign q1    = (count_r > 4'd1) ? mem_r[rd1_idx_s] : 8'h00;
   assign q2    = (count_r > 4'd2) ? mem_r[rd2_idx_s] : 8'h00;

   // Queue bookkeeping; a flush overrides any consume or enqueue in the same cycle.
   always_comb begin
      count_nxt_s = flush ? 4'd0 : (count_r - consumed_s + enq_cnt_s);
      head_nxt_s  = flush ? 3'd0 : ptr_add(head_r, consumed_s);
      tail_nxt_s  = flush ? 3'd0 : ptr_add(tail_r, enq_cnt_s);
      pc_nxt_s    = flush ? flush_addr : (take_s ? (pc_r + ADDR_WIDTH'(enq_cnt_s)) : pc_r);
      valid_nxt_s = flush | addr_valid_r;
      if (flush) begin
         skip_nxt_s = flush_addr[0];
      end else if (start_s) begin
         skip_nxt_s = pc_r[0];
      end else if (take_s) begin
         skip_nxt_s = 1'b0;
      end else begin
         skip_nxt_s = skip_lo_r;
      end
   end

   // Fetch sequencer; the bus cycle is never aborted, so a flush mid-fetch goes STALE.
   always_comb begin
      state_nxt_s = state_r;
      req_nxt_s   = fetch_req;
      addr_nxt_s  = fetch_addr;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_nxt_s = ST_FETCH;
               req_nxt_s   = 1'b1;
               addr_nxt_s  = {pc_r[ADDR_WIDTH-1:1], 1'b0};
            end else begin
               state_nxt_s = ST_IDLE;
               req_nxt_s   = 1'b0;
            end
         end
         ST_FETCH: begin
            if (fetch_ack) begin
               state_nxt_s = ST_IDLE;
               req_nxt_s   = 1'b0;
            end else if (flush) begin
               state_nxt_s = ST_STALE;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_STALE: begin
            if (fetch_ack) begin
               state_nxt_s = ST_IDLE;
               req_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = ST_STALE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            req_nxt_s   = 1'b0;
         end
      endcase
   end

   // State registers and byte store, advanced only on clock enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            mem_r[i] <= 8'h00;
         end
         head_r       <= 3'd0;
         tail_r       <= 3'd0;
         count_r      <= 4'd0;
         pc_r         <= '0;
         skip_lo_r    <= 1'b0;
         addr_valid_r <= 1'b0;
         state_r      <= ST_IDLE;
         fetch_req    <= 1'b0;
         fetch_addr   <= '0;
      end else if (ce) begin
         if (take_s) begin
            mem_r[tail_r] <= wr_byte0_s;
         end
         if (wr_byte1_s) begin
            mem_r[tail_p1_s] <= fetch_data[15:8];
         end
         head_r       <= head_nxt_s;
         tail_r       <= tail_nxt_s;
         count_r      <= count_nxt_s;
         pc_r         <= pc_nxt_s;
         skip_lo_r    <= skip_nxt_s;
         addr_valid_r <= valid_nxt_s;
         state_r      <= state_nxt_s;
         fetch_req    <= req_nxt_s;
         fetch_addr   <= addr_nxt_s;
      end
   end

endmodule
